// File: rtl/adc16dv160_capture_ctrl.sv
// Capture sequencer: turns the ADC sample stream into fixed-length AXI-Stream frames,
// with optional level-sync trigger, test-counter pattern and real-time re-arming.
module adc16dv160_capture_ctrl #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              adc_valid,
   input  logic              cr_start,
   input  logic              cr_test,
   input  logic              cr_rt,
   input  logic              cr_ls,
   input  logic [CNT_W-1:0]  dsize,
   input  logic [15:0]       ls_thr,
   input  logic [CNT_W-1:0]  ls_n,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic              busy,
   output logic              ovf
);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAP, S_FLUSH} state_t;

   state_t             r_state, w_state_nxt;
   logic [DATA_W-1:0]  r_tdata, w_tdata_nxt;
   logic               r_tvalid, w_tvalid_nxt;
   logic               r_tlast, w_tlast_nxt;
   logic               r_ovf, w_ovf_nxt;
   logic               r_busy;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [CNT_W-1:0]   r_run, w_run_nxt;
   logic [DATA_W-1:0]  r_tcnt, w_tcnt_nxt;
   logic               r_test, w_test_nxt;
   logic [CNT_W-1:0]   r_dsize, w_dsize_nxt;
   logic [CNT_W-1:0]   r_lsn, w_lsn_nxt;

   logic [CNT_W-1:0]   w_lsn_eff;
   logic               w_above;
   logic               w_can_load;
   logic               w_last_idx;
   logic               w_load;
   logic               w_new_frame;

   assign w_lsn_eff  = (r_lsn == '0) ? CNT_W'(1) : r_lsn;
   assign w_above    = $signed(adc_data) >= $signed(ls_thr);
   assign w_can_load = !r_tvalid || m_axis_tready;
   assign w_last_idx = (r_cnt == r_dsize - CNT_W'(1));

   // Next-state and datapath decode
   always_comb begin
      w_state_nxt  = r_state;
      w_tdata_nxt  = r_tdata;
      w_tvalid_nxt = r_tvalid;
      w_tlast_nxt  = r_tlast;
      w_ovf_nxt    = r_ovf;
      w_cnt_nxt    = r_cnt;
      w_run_nxt    = r_run;
      w_tcnt_nxt   = r_tcnt;
      w_test_nxt   = r_test;
      w_dsize_nxt  = r_dsize;
      w_lsn_nxt    = r_lsn;
      w_load       = 1'b0;
      w_new_frame  = 1'b0;

      if (r_tvalid && m_axis_tready) begin
         w_tvalid_nxt = 1'b0;
         w_tlast_nxt  = 1'b0;
      end

      case (r_state)
         S_IDLE: begin
            if (cr_start && (dsize != '0)) begin
               w_new_frame = 1'b1;
               w_ovf_nxt   = 1'b0;
            end
         end
         S_ARM: begin
            if (adc_valid) begin
               if (w_above) begin
                  w_run_nxt = r_run + CNT_W'(1);
                  if ((r_run + CNT_W'(1)) == w_lsn_eff) w_load = 1'b1;
               end else begin
                  w_run_nxt = '0;
               end
            end
         end
         S_CAP: begin
            if (adc_valid) begin
               if (w_can_load) w_load    = 1'b1;
               else            w_ovf_nxt = 1'b1;
            end
         end
         S_FLUSH: begin
            if (m_axis_tready) begin
               if (cr_rt && (dsize != '0)) w_new_frame = 1'b1;
               else                        w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Sample load into the output register; the dsize-th beat carries tlast
      if (w_load) begin
         w_tdata_nxt  = r_test ? r_tcnt : adc_data;
         w_tvalid_nxt = 1'b1;
         w_tlast_nxt  = w_last_idx;
         w_cnt_nxt    = r_cnt + CNT_W'(1);
         w_tcnt_nxt   = r_tcnt + DATA_W'(1);
         w_state_nxt  = w_last_idx ? S_FLUSH : S_CAP;
      end

      if (w_new_frame) begin
         w_test_nxt  = cr_test;
         w_dsize_nxt = dsize;
         w_lsn_nxt   = ls_n;
         w_cnt_nxt   = '0;
         w_run_nxt   = '0;
         w_tcnt_nxt  = '0;
         w_state_nxt = cr_ls ? S_ARM : S_CAP;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_tdata  <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_ovf    <= 1'b0;
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_run    <= '0;
         r_tcnt   <= '0;
         r_test   <= 1'b0;
         r_dsize  <= '0;
         r_lsn    <= '0;
      end else begin
         r_tdata  <= w_tdata_nxt;
         r_tvalid <= w_tvalid_nxt;
         r_tlast  <= w_tlast_nxt;
         r_ovf    <= w_ovf_nxt;
         r_busy   <= (w_state_nxt != S_IDLE);
         r_cnt    <= w_cnt_nxt;
         r_run    <= w_run_nxt;
         r_tcnt   <= w_tcnt_nxt;
         r_test   <= w_test_nxt;
         r_dsize  <= w_dsize_nxt;
         r_lsn    <= w_lsn_nxt;
      end
   end

   assign m_axis_tdata  = r_tdata;
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tlast  = r_tlast;
   assign busy          = r_busy;
   assign ovf           = r_ovf;

endmodule
